// File: rtl/neuron_pkg.sv
// Fixed-point types, constants and output saturation shared by the learning-neuron datapath.
package neuron_pkg;

  localparam int unsigned N_SRC     = 32;
  localparam int unsigned DW        = 16;
  localparam int unsigned SW        = $clog2(N_SRC);
  localparam int unsigned AW        = DW + SW;
  localparam int unsigned FRAC_BITS = 12;

  typedef logic signed [DW-1:0] err_t;
  typedef logic signed [AW-1:0] acc_t;

  localparam err_t ERR_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam err_t ERR_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic sat;
    err_t err;
  } sat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } gather_state_t;

  // Clip a wide accumulator to Q4.12 and flag whether clipping happened.
  function automatic sat_t saturate(input acc_t a);
    sat_t r;
    if (a > acc_t'(ERR_MAX)) begin
      r.err = ERR_MAX;
      r.sat = 1'b1;
    end else if (a < acc_t'(ERR_MIN)) begin
      r.err = ERR_MIN;
      r.sat = 1'b1;
    end else begin
      r.err = a[DW-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/backprop_error_gather.sv
// Serially collects error contributions from the enabled downstream neurons,
// sums them at full precision and hands the saturated total upstream.
module backprop_error_gather
  import neuron_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_SRC-1:0] enabled,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    in_src,
  input  logic [DW-1:0]    in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_err,
  output logic             out_sat,
  output logic             busy,
  output logic             proto_err
);

  gather_state_t    state;
  acc_t             acc;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] got;

  logic             src_ok;
  logic             accept;
  acc_t             acc_sum;
  logic [N_SRC-1:0] got_upd;
  sat_t             sat_res;

  // Qualify the incoming contribution against the latched mask.
  always_comb begin
    src_ok  = 32'(in_src) < N_SRC;
    accept  = src_ok && mask[in_src] && !got[in_src];
    acc_sum = acc + acc_t'($signed(in_err));
    got_upd = got | (N_SRC'(1) << in_src);
    sat_res = saturate(acc_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      mask      <= '0;
      got       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask      <= enabled;
            acc       <= '0;
            got       <= '0;
            proto_err <= 1'b0;
            busy      <= 1'b1;
            if (enabled == '0) begin
              state     <= ST_EMIT;
              out_valid <= 1'b1;
              out_err   <= '0;
              out_sat   <= 1'b0;
            end else begin
              state    <= ST_COLLECT;
              in_ready <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (in_valid && in_ready) begin
            if (accept) begin
              acc <= acc_sum;
              got <= got_upd;
              // Final contribution: present the total on the very next cycle.
              if (got_upd == mask) begin
                state     <= ST_EMIT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_err   <= sat_res.err;
                out_sat   <= sat_res.sat;
              end
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
